// File: rtl/async_fifo_pkg.sv
// Shared definitions for both halves of the async FIFO: default sizes and
// Gray/binary pointer conversions (width-agnostic up to 32 bits, zero-extended).
package async_fifo_pkg;

  localparam int DW_DEF = 18;
  localparam int AW_DEF = 7;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above it; zero upper bits are neutral.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_ctrl_ptr_sync.sv
// N-bit two-flop synchroniser for Gray-coded pointers crossing clock domains.
// Shared by both FIFO sides; clears to zero on the async reset.
module ptr_sync #(
  parameter int N = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [N-1:0] d_i,
  output logic [N-1:0] q_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  // Two-stage capture of the foreign-domain pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the async FIFO: read pointer, synchronised write pointer,
// RAM read port and a 2-entry skid buffer presenting a first-word-fall-through stream.
module fifo_rd_ctrl
  import async_fifo_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          rclk,
  input  logic          rrst,
  input  logic [AW:0]   wptr_gray,
  output logic [AW:0]   rptr_gray,
  output logic [AW-1:0] rd_addr,
  input  logic [DW-1:0] rd_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          empty,
  output logic [AW:0]   rd_count
);

  localparam int PW = AW + 1;

  logic [PW-1:0] wptr_sync;
  logic [PW-1:0] wbin;
  logic [PW-1:0] unfetched;
  logic [PW-1:0] rbin_q, rbin_d;
  logic [PW-1:0] rptr_gray_q, rptr_gray_d;
  logic [1:0]    ob_cnt_q, ob_cnt_d;
  logic [DW-1:0] ob0_q, ob0_d;
  logic [DW-1:0] ob1_q, ob1_d;
  logic          inflight_q, inflight_d;
  logic          empty_q, empty_d;
  logic          pop;
  logic          fetch;
  logic [2:0]    occ_after;

  ptr_sync #(.N(PW)) u_wptr_sync (
    .clk_i (rclk),
    .rst_i (rrst),
    .d_i   (wptr_gray),
    .q_o   (wptr_sync)
  );

  // Pointer arithmetic, fetch decision and skid-buffer next state.
  always_comb begin
    wbin        = PW'(gray2bin(32'(wptr_sync)));
    unfetched   = wbin - rbin_q;
    pop         = (ob_cnt_q != 2'd0) & out_ready;
    // Slots still claimed after this edge; a fetch needs one free for the RAM word.
    occ_after   = {1'b0, ob_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    fetch       = (unfetched != '0) & (occ_after < 3'd2);
    rbin_d      = fetch ? (rbin_q + {{AW{1'b0}}, 1'b1}) : rbin_q;
    rptr_gray_d = PW'(bin2gray(32'(rbin_d)));
    inflight_d  = fetch;

    ob0_d    = ob0_q;
    ob1_d    = ob1_q;
    ob_cnt_d = ob_cnt_q;
    case ({pop, inflight_q})
      2'b11: begin
        if (ob_cnt_q == 2'd1) begin
          ob0_d = rd_data;
        end else begin
          ob0_d = ob1_q;
          ob1_d = rd_data;
        end
      end
      2'b10: begin
        ob0_d    = ob1_q;
        ob_cnt_d = ob_cnt_q - 2'd1;
      end
      2'b01: begin
        if (ob_cnt_q == 2'd0) begin
          ob0_d = rd_data;
        end else begin
          ob1_d = rd_data;
        end
        ob_cnt_d = ob_cnt_q + 2'd1;
      end
      default: begin
        ob_cnt_d = ob_cnt_q;
      end
    endcase

    rd_count = unfetched + {{AW{1'b0}}, inflight_q} + {{(PW-2){1'b0}}, ob_cnt_q};
    empty_d  = (rd_count == '0);
  end

  // Read-domain state registers.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin_q      <= '0;
      rptr_gray_q <= '0;
      ob_cnt_q    <= 2'd0;
      ob0_q       <= '0;
      ob1_q       <= '0;
      inflight_q  <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      rbin_q      <= rbin_d;
      rptr_gray_q <= rptr_gray_d;
      ob_cnt_q    <= ob_cnt_d;
      ob0_q       <= ob0_d;
      ob1_q       <= ob1_d;
      inflight_q  <= inflight_d;
      empty_q     <= empty_d;
    end
  end

  assign rptr_gray = rptr_gray_q;
  assign rd_addr   = rbin_q[AW-1:0];
  assign out_valid = (ob_cnt_q != 2'd0);
  assign out_data  = ob0_q;
  assign empty     = empty_q;

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl (AW = 3): word-level reference model, a cycle table for
// the first-word latency, directed corner sequences and a randomised stream.
module tb_fifo_rd_ctrl;

  localparam int DW    = 18;
  localparam int AW    = 3;
  localparam int DEPTH = 8;

  logic          rclk = 1'b0;
  logic          rrst;
  logic [AW:0]   wptr_gray;
  logic [AW:0]   rptr_gray;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          empty;
  logic [AW:0]   rd_count;

  logic [DW-1:0] mem [DEPTH];

  int tests = 0;
  int fails = 0;
  // Model: words written, write count seen one/two edges ago, words consumed.
  int wcount, vis1, vis2, popped, prev_cnt;

  always #5 rclk = ~rclk;

  always @(posedge rclk) rd_data <= mem[rd_addr];

  fifo_rd_ctrl #(.DW(DW), .AW(AW)) dut (
    .rclk      (rclk),
    .rrst      (rrst),
    .wptr_gray (wptr_gray),
    .rptr_gray (rptr_gray),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .empty     (empty),
    .rd_count  (rd_count)
  );

  function automatic logic [DW-1:0] word_val(input int n);
    return DW'((n * 2749 + 17) ^ (n << 9));
  endfunction

  function automatic logic [AW:0] to_gray(input int n);
    logic [AW:0] b;
    b = (AW+1)'(n);
    return b ^ (b >> 1);
  endfunction

  function automatic int from_gray(input logic [AW:0] g);
    logic [AW:0] r;
    r[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) r[i] = r[i+1] ^ g[i];
    return int'(r);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic write_word();
    mem[wcount % DEPTH] = word_val(wcount);
    wcount++;
    wptr_gray = to_gray(wcount);
  endtask

  // Write only into slots the read side has already fetched.
  task automatic try_write();
    if (((wcount - from_gray(rptr_gray)) & 15) < DEPTH) write_word();
  endtask

  // One clock edge plus the model checks that hold on every cycle.
  task automatic tick();
    bit pre_valid, pre_pop;
    int w_edge, exp_cnt;
    pre_valid = out_valid;
    pre_pop   = out_valid & out_ready;
    w_edge    = wcount;
    @(posedge rclk);
    #1;
    vis2 = vis1;
    vis1 = w_edge;
    if (pre_pop) popped++;
    exp_cnt = (vis2 - popped) & 15;
    chk("rd_count", int'(rd_count), exp_cnt);
    chk("empty", int'(empty), int'(prev_cnt == 0));
    prev_cnt = exp_cnt;
    if (out_valid) chk("head_data", int'(out_data), int'(word_val(popped)));
    if (pre_valid && !pre_pop) chk("stall_valid", int'(out_valid), 1);
  endtask

  task automatic do_reset();
    rrst      = 1'b1;
    wptr_gray = '0;
    out_ready = 1'b0;
    wcount = 0; vis1 = 0; vis2 = 0; popped = 0; prev_cnt = 0;
    repeat (2) @(posedge rclk);
    #1;
    rrst = 1'b0;
  endtask

  typedef struct {
    bit wr;
    bit rdy;
    bit exp_valid;
    int exp_cnt;
    bit exp_empty;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int nvalid, first, last, last_addr, wp, rp;

    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 0, 1'b1};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1, 1'b1};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1, 1'b0};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 0, 1'b1};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 0, 1'b1};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1, 1'b1};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 2, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 2, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1, 1'b0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 0, 1'b1};

    do_reset();
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_data", int'(out_data), 0);
    chk("rst_count", int'(rd_count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_rptr", int'(rptr_gray), 0);
    chk("rst_addr", int'(rd_addr), 0);

    // First-word latency and a short two-word stream.
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) write_word();
      out_ready = tbl[i].rdy;
      tick();
      chk($sformatf("tbl%0d_valid", i), int'(out_valid), int'(tbl[i].exp_valid));
      chk($sformatf("tbl%0d_count", i), int'(rd_count), tbl[i].exp_cnt);
      chk($sformatf("tbl%0d_empty", i), int'(empty), int'(tbl[i].exp_empty));
    end

    // Burst of 5 with the consumer always ready: no bubbles.
    do_reset();
    out_ready = 1'b1;
    nvalid = 0; first = -1; last = -1;
    for (int k = 0; k < 20; k++) begin
      if (k < 5) write_word();
      tick();
      if (out_valid) begin
        nvalid++;
        if (first < 0) first = k;
        last = k;
      end
    end
    chk("burst_nvalid", nvalid, 5);
    chk("burst_span", last - first + 1, 5);
    chk("burst_rptr", int'(rptr_gray), int'(to_gray(5)));
    chk("burst_empty", int'(empty), 1);

    // Backpressure: buffer holds 2, writer fills the remaining 8 RAM slots.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 30; k++) begin
      try_write();
      tick();
    end
    chk("bp_rbin", from_gray(rptr_gray), 2);
    chk("bp_written", wcount, 10);
    chk("bp_count", int'(rd_count), 10);
    chk("bp_valid", int'(out_valid), 1);
    out_ready = 1'b1;
    repeat (20) tick();
    chk("bp_drained", popped, 10);
    chk("bp_empty", int'(empty), 1);

    // Full depth visible at once with nothing fetched yet.
    do_reset();
    for (int i = 0; i < DEPTH; i++) mem[i] = word_val(i);
    wcount    = DEPTH;
    wptr_gray = to_gray(DEPTH);
    tick();
    tick();
    chk("full_count", int'(rd_count), 8);
    chk("full_rptr", int'(rptr_gray), 0);
    tick();
    chk("full_empty", int'(empty), 0);
    out_ready = 1'b1;
    repeat (20) tick();
    chk("full_drained", popped, 8);

    // Wrap-around: 20 words through an 8-deep RAM, address steps by one.
    do_reset();
    out_ready = 1'b1;
    last_addr = 0;
    for (int k = 0; k < 60; k++) begin
      if (wcount < 20) try_write();
      tick();
      if (int'(rd_addr) != last_addr) begin
        chk("wrap_addr_step", int'(rd_addr), (last_addr + 1) % DEPTH);
        last_addr = int'(rd_addr);
      end
    end
    chk("wrap_popped", popped, 20);
    chk("wrap_addr", int'(rd_addr), 4);
    chk("wrap_rbin", from_gray(rptr_gray), 4);

    // Reset in mid-stream takes effect without a clock edge.
    do_reset();
    repeat (3) begin
      write_word();
      tick();
    end
    repeat (4) tick();
    chk("mid_valid_before", int'(out_valid), 1);
    rrst = 1'b1;
    #1;
    chk("mid_valid", int'(out_valid), 0);
    chk("mid_count", int'(rd_count), 0);
    chk("mid_rptr", int'(rptr_gray), 0);
    chk("mid_empty", int'(empty), 1);
    do_reset();

    // Randomised traffic in phases of varying write and consume rates.
    for (int k = 0; k < 1500; k++) begin
      if (k % 100 == 0) begin
        wp = $urandom_range(10, 100);
        rp = $urandom_range(10, 100);
      end
      if ($urandom_range(0, 99) < wp) try_write();
      out_ready = ($urandom_range(0, 99) < rp);
      tick();
    end
    out_ready = 1'b1;
    repeat (30) tick();
    chk("rand_drained", popped, wcount);
    chk("rand_empty", int'(empty), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
